// File: rtl/word_serializer.sv
// ============================================================================
// word_serializer: splits each accepted 32-bit word into four bytes on a
// valid/ready byte stream. The optional out_parity port is enabled by
// defining WORD_SERIALIZER_PARITY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module word_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy
`ifdef WORD_SERIALIZER_PARITY_EN
  ,
  output logic        out_parity
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [31:0] word, word_nxt;
  logic [1:0]  byte_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 2'd0;
      word  <= 32'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      word  <= word_nxt;
    end
  end

  // The last byte's handshake also frees the holding register, so a new word
  // can be taken in the same cycle without a bubble.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    word_nxt  = word;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_nxt  = in_data;
          idx_nxt   = 2'd0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = (idx == 2'd3);
        if (out_ready) begin
          if (idx != 2'd3) begin
            idx_nxt = idx + 2'd1;
          end else begin
            in_ready = 1'b1;
            idx_nxt  = 2'd0;
            if (in_valid) begin
              word_nxt = in_data;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 2'd0;
      end
    endcase
  end

  assign byte_sel = MSB_FIRST ? ~idx : idx;
  assign out_data = word[{byte_sel, 3'b000} +: 8];
  assign busy     = out_valid;

`ifdef WORD_SERIALIZER_PARITY_EN
  assign out_parity = out_valid & (^out_data);
`endif

endmodule

`default_nettype wire

// File: tb/tb_word_serializer.sv
// ============================================================================
// tb_word_serializer: directed bench for word_serializer, both byte orders,
// with per-instance expected-byte queues.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_word_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready0, out_valid0, out_last0, busy0;
  logic [7:0]  out_data0;
  logic        in_ready1, out_valid1, out_last1, busy1;
  logic [7:0]  out_data1;
`ifdef WORD_SERIALIZER_PARITY_EN
  logic        out_parity0, out_parity1;
`endif

  int total = 0;
  int bad   = 0;
  int accepted = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];

  word_serializer #(.MSB_FIRST(1'b0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_data  (out_data0),
    .out_last  (out_last0),
    .busy      (busy0)
`ifdef WORD_SERIALIZER_PARITY_EN
    ,
    .out_parity(out_parity0)
`endif
  );

  word_serializer #(.MSB_FIRST(1'b1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .out_last  (out_last1),
    .busy      (busy1)
`ifdef WORD_SERIALIZER_PARITY_EN
    ,
    .out_parity(out_parity1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic check_byte(input string tag, input logic valid, input logic [7:0] data,
                            input logic last, inout logic [8:0] q[$]);
    logic [8:0] e;
    if (valid && out_ready) begin
      if (q.size() == 0) begin
        chk({tag, " unexpected byte"}, 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk({tag, " data"}, {24'd0, data}, {24'd0, e[7:0]});
        chk({tag, " last"}, {31'd0, last}, {31'd0, e[8]});
      end
    end
  endtask

  task automatic tick();
    logic [7:0] b;
    if (in_valid && in_ready0) begin
      accepted++;
      for (int i = 0; i < 4; i++) begin
        b = in_data[8*i +: 8];
        q0.push_back({(i == 3), b});
        b = in_data[8*(3-i) +: 8];
        q1.push_back({(i == 3), b});
      end
    end
    chk("busy0", {31'd0, busy0}, {31'd0, out_valid0});
`ifdef WORD_SERIALIZER_PARITY_EN
    if (out_valid0 && q0.size() != 0)
      chk("parity0", {31'd0, out_parity0}, {31'd0, ^q0[0][7:0]});
    else if (!out_valid0)
      chk("parity0 idle", {31'd0, out_parity0}, 32'd0);
`endif
    check_byte("lsb", out_valid0, out_data0, out_last0, q0);
    check_byte("msb", out_valid1, out_data1, out_last1, q1);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rw [3];
    int budget;
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst in_ready", {31'd0, in_ready0}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst out_last", {31'd0, out_last0}, 32'd0);
    chk("rst busy", {31'd0, busy0}, 32'd0);
    chk("rst out_data", {24'd0, out_data0}, 32'd0);
    chk("rst out_data msb", {24'd0, out_data1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word, both byte orders, one byte per cycle.
    drive(1'b1, 32'h44332211, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, $urandom, 1'b1);
      chk("single out_valid", {31'd0, out_valid0}, 32'd1);
      tick();
    end
    drive(1'b0, 32'd0, 1'b1);
    chk("single idle out_valid", {31'd0, out_valid0}, 32'd0);
    chk("single idle in_ready", {31'd0, in_ready0}, 32'd1);
    tick();
    drive(1'b1, 32'hA1B2C3D4, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 1'b1);
      tick();
    end

    // Back-to-back words: in_ready only in idle and on the index-3 cycle.
    drive(1'b1, 32'h03020100, 1'b1);
    chk("b2b idle in_ready", {31'd0, in_ready0}, 32'd1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(i < 4, 32'h07060504, 1'b1);
      chk("b2b out_valid", {31'd0, out_valid0}, 32'd1);
      chk("b2b in_ready", {31'd0, in_ready0}, {31'd0, (i % 4) == 3});
      tick();
    end
    drive(1'b0, 32'd0, 1'b1);
    chk("b2b end out_valid", {31'd0, out_valid0}, 32'd0);
    tick();

    // Backpressure while 0x22 is shown, then again on the last byte.
    drive(1'b1, 32'h44332211, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 1'b0);
      chk("bp data", {24'd0, out_data0}, 32'h22);
      chk("bp last", {31'd0, out_last0}, 32'd0);
      chk("bp in_ready", {31'd0, in_ready0}, 32'd0);
      chk("bp out_valid", {31'd0, out_valid0}, 32'd1);
      tick();
    end
    drive(1'b0, 32'd0, 1'b1);
    chk("bp resume data", {24'd0, out_data0}, 32'h22);
    tick();
    drive(1'b0, 32'd0, 1'b1);
    chk("bp resume next", {24'd0, out_data0}, 32'h33);
    tick();
    drive(1'b1, 32'h55667788, 1'b0);
    chk("bp idx3 in_ready", {31'd0, in_ready0}, 32'd0);
    chk("bp idx3 last", {31'd0, out_last0}, 32'd1);
    tick();
    drive(1'b0, 32'd0, 1'b1);
    chk("bp idx3 release in_ready", {31'd0, in_ready0}, 32'd1);
    tick();
    drive(1'b0, 32'd0, 1'b1);
    chk("bp done out_valid", {31'd0, out_valid0}, 32'd0);
    tick();

    // Reset mid-word discards remaining bytes.
    drive(1'b1, 32'hDEADBEEF, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", {31'd0, out_valid0}, 32'd0);
    chk("midrst busy", {31'd0, busy0}, 32'd0);
    chk("midrst in_ready", {31'd0, in_ready0}, 32'd1);
    chk("midrst out_data", {24'd0, out_data0}, 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h01020304, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b1);
    chk("post rst first byte", {24'd0, out_data0}, 32'h04);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 1'b1);
      tick();
    end

    // Parity pattern word; parity itself is checked only when the port exists.
    drive(1'b1, 32'h00070301, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 1'b1);
      tick();
    end

    // Random words under random downstream stalls.
    rw[0] = $urandom;
    rw[1] = $urandom;
    rw[2] = $urandom;
    accepted = 0;
    budget = 0;
    while ((accepted < 3 || q0.size() != 0) && budget < 200) begin
      drive(accepted < 3, (accepted < 3) ? rw[accepted] : 32'd0, 1'($urandom_range(0, 1)));
      tick();
      budget++;
    end
    chk("random drain in budget", {31'd0, budget < 200}, 32'd1);
    drive(1'b0, 32'd0, 1'b1);
    chk("final queue empty", q0.size() + q1.size(), 32'd0);
    chk("final out_valid", {31'd0, out_valid0}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
